// File: rtl/calc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_ctrl_if
// Brief    : Operand/opcode bus and start/done handshake between the
//            sequencing controller and the ALU/display datapath.
// Revision : 1.0
// ============================================================================
interface calc_seq_ctrl_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [2:0]       func_out;
    logic             alu_start;
    logic             alu_done;
    logic             alu_ovf;

    modport master (
        output a_out,
        output b_out,
        output func_out,
        output alu_start,
        input  alu_done,
        input  alu_ovf
    );

    modport slave (
        input  a_out,
        input  b_out,
        input  func_out,
        input  alu_start,
        output alu_done,
        output alu_ovf
    );
endinterface
`default_nettype wire

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_ctrl
// Brief    : Key-driven operand/op entry, ALU launch with timeout guard,
//            overflow flagging and auto-alternating display-page select.
// Revision : 1.0
// ============================================================================
module calc_seq_ctrl #(
    parameter int WIDTH   = 6,
    parameter int TIMEOUT = 1024,
    parameter int DWELL   = 50000000
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             key_next,
    input  wire logic             key_clr,
    input  wire logic [WIDTH-1:0] sw_val,
    input  wire logic [1:0]       sw_func,
    calc_seq_ctrl_if.master       alu,
    output logic                  busy,
    output logic                  err,
    output logic [2:0]            state_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GOT_A = 3'd1,
        S_GOT_B = 3'd2,
        S_EXEC  = 3'd3,
        S_SHOW  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // One counter serves both the EXEC timeout and the SHOW dwell timer.
    localparam int c_CNT_MAX = (TIMEOUT > DWELL) ? TIMEOUT : DWELL;
    localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST    = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load_a;
    logic               w_load_b;
    logic               w_load_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic               r_show_ab;
    logic               r_start;
    logic               r_busy;
    logic               r_err;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_load_op   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_next) begin
                    w_state_nxt = S_GOT_A;
                    w_load_a    = 1'b1;
                end
            end
            S_GOT_A: begin
                if (key_next) begin
                    w_state_nxt = S_GOT_B;
                    w_load_b    = 1'b1;
                end
            end
            S_GOT_B: begin
                if (key_next) begin
                    w_state_nxt = S_EXEC;
                    w_load_op   = 1'b1;
                end
            end
            S_EXEC: begin
                // A done arriving on the timeout cycle still completes normally.
                if (alu.alu_done) begin
                    w_state_nxt = S_SHOW;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_SHOW, S_ERR: begin
                if (key_next) begin
                    w_state_nxt = S_GOT_A;
                    w_load_a    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (key_clr) begin
            w_state_nxt = S_IDLE;
            w_load_a    = 1'b0;
            w_load_b    = 1'b0;
            w_load_op   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= 2'b00;
            r_show_ab <= 1'b1;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_load_a) begin
                r_a <= sw_val;
            end
            if (w_load_b) begin
                r_b <= sw_val;
            end
            if (w_load_op) begin
                r_op <= sw_func;
            end

            r_start <= (r_state == S_GOT_B) && (w_state_nxt == S_EXEC);
            r_busy  <= (w_state_nxt == S_EXEC);

            if ((r_state == S_EXEC) && (w_state_nxt == S_SHOW)) begin
                r_err <= alu.alu_ovf;
            end else if (w_state_nxt == S_ERR) begin
                r_err <= 1'b1;
            end else if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_GOT_A)) begin
                r_err <= 1'b0;
            end

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_EXEC) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end else if (r_state == S_SHOW) begin
                r_cnt <= (r_cnt == c_DWELL_LAST) ? '0 : r_cnt + c_CNT_ONE;
            end else begin
                r_cnt <= '0;
            end

            // Result page first on SHOW entry, then alternate every DWELL cycles.
            if (w_state_nxt != S_SHOW) begin
                r_show_ab <= 1'b1;
            end else if (r_state != S_SHOW) begin
                r_show_ab <= 1'b0;
            end else if (r_cnt == c_DWELL_LAST) begin
                r_show_ab <= ~r_show_ab;
            end
        end
    end

    assign alu.a_out     = r_a;
    assign alu.b_out     = r_b;
    assign alu.func_out  = {r_show_ab, r_op};
    assign alu.alu_start = r_start;
    assign busy          = r_busy;
    assign err           = r_err;
    assign state_out     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_seq_ctrl
// Brief    : Directed self-checking bench for calc_seq_ctrl (TIMEOUT=8, DWELL=4).
// Revision : 1.0
// ============================================================================
module tb_calc_seq_ctrl;

    localparam int c_WIDTH   = 6;
    localparam int c_TIMEOUT = 8;
    localparam int c_DWELL   = 4;

    logic               clk;
    logic               rst_n;
    logic               key_next;
    logic               key_clr;
    logic [c_WIDTH-1:0] sw_val;
    logic [1:0]         sw_func;
    logic               busy;
    logic               err;
    logic [2:0]         state_out;

    int checks = 0;
    int errors = 0;

    calc_seq_ctrl_if #(.WIDTH(c_WIDTH)) alu_if ();

    calc_seq_ctrl #(
        .WIDTH   (c_WIDTH),
        .TIMEOUT (c_TIMEOUT),
        .DWELL   (c_DWELL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_next  (key_next),
        .key_clr   (key_clr),
        .sw_val    (sw_val),
        .sw_func   (sw_func),
        .alu       (alu_if),
        .busy      (busy),
        .err       (err),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_next(input logic [c_WIDTH-1:0] v, input logic [1:0] f);
        sw_val   = v;
        sw_func  = f;
        key_next = 1'b1;
        step();
        key_next = 1'b0;
    endtask

    task automatic pulse_done(input logic ovf);
        alu_if.alu_done = 1'b1;
        alu_if.alu_ovf  = ovf;
        step();
        alu_if.alu_done = 1'b0;
        alu_if.alu_ovf  = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        key_next        = 1'b0;
        key_clr         = 1'b0;
        sw_val          = '0;
        sw_func         = 2'b00;
        alu_if.alu_done = 1'b0;
        alu_if.alu_ovf  = 1'b0;
        step();
        step();

        check("rst_state", state_out, 3'd0);
        check("rst_a", alu_if.a_out, 6'd0);
        check("rst_b", alu_if.b_out, 6'd0);
        check("rst_func", alu_if.func_out, 3'b100);
        check("rst_start", alu_if.alu_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        step();

        // Entry sequence and launch
        press_next(6'd5, 2'b00);
        check("t1_state_a", state_out, 3'd1);
        check("t1_a", alu_if.a_out, 6'd5);
        press_next(6'h3E, 2'b00);
        check("t1_state_b", state_out, 3'd2);
        check("t1_b", alu_if.b_out, 6'h3E);
        press_next(6'd0, 2'b10);
        check("t1_state_exec", state_out, 3'd3);
        check("t1_func", alu_if.func_out, 3'b110);
        check("t1_start_hi", alu_if.alu_start, 1'b1);
        check("t1_busy", busy, 1'b1);
        sw_func = 2'b01;
        step();
        check("t1_start_lo", alu_if.alu_start, 1'b0);
        check("t1_busy2", busy, 1'b1);
        check("t1_func_latched", alu_if.func_out, 3'b110);
        press_next(6'd9, 2'b11);
        check("t1_next_ignored", state_out, 3'd3);
        check("t1_a_kept", alu_if.a_out, 6'd5);

        // Completion and display alternation
        pulse_done(1'b0);
        check("t2_state_show", state_out, 3'd4);
        check("t2_err", err, 1'b0);
        check("t2_busy", busy, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            check($sformatf("t2_show_ab_%0d", i), alu_if.func_out[2], ((i - 1) / 4) % 2);
            step();
        end

        // Timeout path
        press_next(6'd1, 2'b00);
        check("t3_state_a", state_out, 3'd1);
        press_next(6'd2, 2'b00);
        press_next(6'd0, 2'b11);
        check("t3_start", alu_if.alu_start, 1'b1);
        for (int i = 1; i <= 7; i++) step();
        check("t3_still_exec", state_out, 3'd3);
        check("t3_err_lo", err, 1'b0);
        step();
        check("t3_state_err", state_out, 3'd5);
        check("t3_err_hi", err, 1'b1);
        check("t3_busy_lo", busy, 1'b0);
        pulse_done(1'b0);
        check("t3_done_ignored", state_out, 3'd5);
        check("t3_err_sticky", err, 1'b1);
        press_next(6'd7, 2'b00);
        check("t3_recover_state", state_out, 3'd1);
        check("t3_recover_a", alu_if.a_out, 6'd7);
        check("t3_recover_err", err, 1'b0);

        // Overflow and stray done in SHOW
        press_next(6'd4, 2'b00);
        press_next(6'd0, 2'b01);
        check("t4_func", alu_if.func_out, 3'b101);
        pulse_done(1'b1);
        check("t4_state_show", state_out, 3'd4);
        check("t4_err_ovf", err, 1'b1);
        pulse_done(1'b0);
        check("t4_stray_done", state_out, 3'd4);
        check("t4_err_kept", err, 1'b1);

        // Clear priority and abandoned operation
        press_next(6'd9, 2'b00);
        check("t5_a", alu_if.a_out, 6'd9);
        check("t5_err_clr", err, 1'b0);
        press_next(6'd10, 2'b00);
        check("t5_state_b", state_out, 3'd2);
        key_clr = 1'b1;
        press_next(6'd20, 2'b11);
        key_clr = 1'b0;
        check("t5_clr_state", state_out, 3'd0);
        check("t5_clr_b", alu_if.b_out, 6'd10);
        check("t5_clr_a", alu_if.a_out, 6'd9);
        press_next(6'd11, 2'b00);
        press_next(6'd12, 2'b00);
        press_next(6'd0, 2'b10);
        check("t5_exec", state_out, 3'd3);
        key_clr = 1'b1;
        step();
        key_clr = 1'b0;
        check("t5_exec_clr", state_out, 3'd0);
        check("t5_exec_clr_busy", busy, 1'b0);
        pulse_done(1'b1);
        check("t5_late_done", state_out, 3'd0);
        check("t5_late_err", err, 1'b0);
        check("t5_func_idle", alu_if.func_out, 3'b110);

        // Asynchronous reset mid-EXEC
        press_next(6'd1, 2'b00);
        press_next(6'd2, 2'b00);
        press_next(6'd0, 2'b11);
        check("t6_exec", state_out, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_state", state_out, 3'd0);
        check("t6_start", alu_if.alu_start, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_a", alu_if.a_out, 6'd0);
        check("t6_b", alu_if.b_out, 6'd0);
        check("t6_func", alu_if.func_out, 3'b100);
        #1;
        rst_n = 1'b1;
        step();
        check("t6_post_state", state_out, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
